// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared constants and helpers for the polyphonic piano voice block
package piano_pkg;

  localparam int HP_W = 18;

  // Half-periods at 100 MHz, C4 up to D#5
  localparam logic [HP_W-1:0] HALF_PERIOD [16] = '{
    18'd191110, 18'd180388, 18'd170265, 18'd160705,
    18'd151685, 18'd143172, 18'd135139, 18'd127551,
    18'd120395, 18'd113636, 18'd107259, 18'd101239,
    18'd95557,  18'd90193,  18'd85131,  18'd80352
  };

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  // A shift that empties the entry still leaves a legal half-period of 1
  function automatic logic [HP_W-1:0] halfFor(input int key, input int shift);
    logic [HP_W-1:0] h;
    h = HALF_PERIOD[key % 16] >> shift;
    return (h == '0) ? HP_W'(1) : h;
  endfunction

endpackage

// File: rtl/piano_voice.sv
// rtl/piano_voice.sv - one square-wave voice; counts a half-period and toggles sq while valid
module piano_voice
  import piano_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            doAssign,
  input  logic            doRelease,
  input  logic [HP_W-1:0] half,
  output logic            valid,
  output logic            sq
);

  logic [HP_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || doRelease) begin
      valid <= 1'b0;
      sq    <= 1'b0;
      cnt   <= '0;
    end else if (doAssign) begin
      valid <= 1'b1;
      sq    <= 1'b0;
      cnt   <= '0;
    end else if (valid) begin
      if (cnt >= half - HP_W'(1)) begin
        cnt <= '0;
        sq  <= ~sq;
      end else begin
        cnt <= cnt + HP_W'(1);
      end
    end
  end

endmodule

// File: rtl/poly_piano_voice.sv
// rtl/poly_piano_voice.sv - debounced key scan, voice allocation and PWM mix of square voices
module poly_piano_voice
  import piano_pkg::*;
#(
  parameter int NUM_KEYS     = 16,
  parameter int NUM_VOICES   = 4,
  parameter int DEBOUNCE_CYC = 4,
  parameter int DIV_SHIFT    = 0
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [NUM_KEYS-1:0]                sw,
  output logic                               audioOut,
  output logic [clog2(NUM_VOICES+1)-1:0]     activeVoices,
  output logic [clog2(NUM_KEYS)-1:0]         topKey,
  output logic                               topKeyValid,
  output logic                               dropPulse
);

  localparam int KW = clog2(NUM_KEYS);
  localparam int AW = clog2(NUM_VOICES + 1);
  localparam int PW = (NUM_VOICES > 1) ? clog2(NUM_VOICES) : 1;
  localparam int DW = clog2(DEBOUNCE_CYC + 1);

  logic [NUM_KEYS-1:0]   sync1, sync2, keyDb;
  logic [DW-1:0]         dbCnt [NUM_KEYS];
  logic [KW-1:0]         scanIdx;
  logic [KW-1:0]         voiceKey [NUM_VOICES];
  logic [HP_W-1:0]       voiceHalf [NUM_VOICES];
  logic [NUM_VOICES-1:0] valid, sq, assignOh, releaseOh;
  logic                  scanDb, hit, freeFound, dropNext;
  logic [AW-1:0]         sumSq, popValid;
  logic [KW-1:0]         firstKey;
  logic [PW-1:0]         pwmCnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      keyDb <= '0;
      for (int k = 0; k < NUM_KEYS; k++) dbCnt[k] <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (sync2[k] != keyDb[k]) begin
          if (dbCnt[k] == DW'(DEBOUNCE_CYC - 1)) begin
            keyDb[k] <= sync2[k];
            dbCnt[k] <= '0;
          end else begin
            dbCnt[k] <= dbCnt[k] + DW'(1);
          end
        end else begin
          dbCnt[k] <= '0;
        end
      end
    end
  end

  // Only the key under scanIdx is examined, so at most one voice changes per cycle
  always_comb begin
    assignOh  = '0;
    releaseOh = '0;
    hit       = 1'b0;
    freeFound = 1'b0;
    dropNext  = 1'b0;
    scanDb    = keyDb[scanIdx];
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (valid[v] && voiceKey[v] == scanIdx) begin
        hit          = 1'b1;
        releaseOh[v] = ~scanDb;
      end
    end
    if (scanDb && !hit) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (!valid[v] && !freeFound) begin
          freeFound   = 1'b1;
          assignOh[v] = 1'b1;
        end
      end
      dropNext = ~freeFound;
    end
  end

  always_comb begin
    sumSq    = '0;
    popValid = '0;
    firstKey = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sumSq        = sumSq + AW'(sq[v]);
      popValid     = popValid + AW'(valid[v]);
      voiceHalf[v] = halfFor(int'(voiceKey[v]), DIV_SHIFT);
    end
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (keyDb[k]) firstKey = KW'(k);
    end
  end

  genvar gv;
  generate
    for (gv = 0; gv < NUM_VOICES; gv++) begin : gVoice
      piano_voice uVoice (
        .CLK       (CLK),
        .RST       (RST),
        .doAssign  (assignOh[gv]),
        .doRelease (releaseOh[gv]),
        .half      (voiceHalf[gv]),
        .valid     (valid[gv]),
        .sq        (sq[gv])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      scanIdx      <= '0;
      pwmCnt       <= '0;
      audioOut     <= 1'b0;
      activeVoices <= '0;
      topKey       <= '0;
      topKeyValid  <= 1'b0;
      dropPulse    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) voiceKey[v] <= '0;
    end else begin
      scanIdx      <= (scanIdx == KW'(NUM_KEYS - 1)) ? '0 : scanIdx + KW'(1);
      pwmCnt       <= (pwmCnt == PW'(NUM_VOICES - 1)) ? '0 : pwmCnt + PW'(1);
      audioOut     <= (int'(pwmCnt) < int'(sumSq));
      activeVoices <= popValid;
      topKey       <= firstKey;
      topKeyValid  <= |keyDb;
      dropPulse    <= dropNext;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (assignOh[v]) voiceKey[v] <= scanIdx;
      end
    end
  end

endmodule

// File: tb/tb_poly_piano_voice.sv
// tb/tb_poly_piano_voice.sv - directed and randomized checks of poly_piano_voice against key-level expectations
module tb_poly_piano_voice;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] sw  = '0;
  logic        audioOut;
  logic [2:0]  activeVoices;
  logic [3:0]  topKey;
  logic        topKeyValid;
  logic        dropPulse;

  int vectors     = 0;
  int miscompares = 0;
  int dropSeen    = 0;
  int minActive   = 99;

  always #5 CLK = ~CLK;

  poly_piano_voice #(
    .NUM_KEYS(16), .NUM_VOICES(4), .DEBOUNCE_CYC(4), .DIV_SHIFT(10)
  ) dut (
    .CLK(CLK), .RST(RST), .sw(sw), .audioOut(audioOut), .activeVoices(activeVoices),
    .topKey(topKey), .topKeyValid(topKeyValid), .dropPulse(dropPulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (dropPulse === 1'b1) dropSeen++;
    if (int'(activeVoices) < minActive) minActive = int'(activeVoices);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  function automatic int popc(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic checkAllZero(input string tag);
    check({tag, "_audio"}, 32'(audioOut), 0);
    check({tag, "_active"}, 32'(activeVoices), 0);
    check({tag, "_topvalid"}, 32'(topKeyValid), 0);
    check({tag, "_drop"}, 32'(dropPulse), 0);
  endtask

  initial begin
    int t;
    int highs[$];
    int starts[$];
    int badGaps;
    int burstLen;
    int pop;
    int expDrops;
    logic [15:0] r;

    // reset held with every key pressed
    RST = 1'b1;
    sw  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAllZero("reset");
    end

    // single key 0: assignment, then square-wave shape seen through the PWM
    RST = 1'b0;
    sw  = 16'h0001;
    t = 0;
    while (activeVoices !== 3'd1 && t < 30) begin
      tick();
      t++;
    end
    check("single_active", 32'(activeVoices), 1);
    check("single_latency_ok", 32'(t <= 24), 1);
    check("single_topkey", 32'(topKey), 0);
    check("single_topvalid", 32'(topKeyValid), 1);

    for (int c = 0; c < 1600; c++) begin
      tick();
      if (audioOut === 1'b1) highs.push_back(c);
    end
    badGaps = 0;
    for (int i = 0; i < highs.size(); i++) begin
      if (i == 0 || highs[i] - highs[i-1] > 100) starts.push_back(highs[i]);
      else if (highs[i] - highs[i-1] != 4) badGaps++;
    end
    check("single_burst_count", 32'(starts.size() >= 3), 1);
    check("single_duty_gaps", 32'(badGaps), 0);
    if (starts.size() >= 3) begin
      check("single_period_a", 32'(starts[1] - starts[0]), 372);
      check("single_period_b", 32'(starts[2] - starts[1]), 372);
      burstLen = 0;
      foreach (highs[i]) if (highs[i] >= starts[1] && highs[i] < starts[2]) burstLen++;
      check("single_burst_len", 32'(burstLen == 46 || burstLen == 47), 1);
    end

    // five keys on four voices: key 4 is dropped once per scan
    sw = 16'h001F;
    run(60);
    check("full_active", 32'(activeVoices), 4);
    dropSeen = 0;
    run(64);
    check("full_drops", 32'(dropSeen), 4);
    check("full_topkey", 32'(topKey), 0);

    // releasing key 1 frees a voice that key 4 then takes
    sw = 16'h001D;
    minActive = 99;
    run(60);
    check("release_dip", 32'(minActive), 3);
    check("release_active", 32'(activeVoices), 4);
    dropSeen = 0;
    run(64);
    check("release_drops", 32'(dropSeen), 0);
    check("release_topkey", 32'(topKey), 0);

    // short glitches must not pass the debouncer
    sw = 16'h001F;
    run(2);
    sw = 16'h001D;
    dropSeen = 0;
    minActive = 99;
    run(40);
    check("glitch_high_drops", 32'(dropSeen), 0);
    check("glitch_high_active", 32'(activeVoices), 4);
    check("glitch_high_topvalid", 32'(topKeyValid), 1);
    sw = 16'h0019;
    run(2);
    sw = 16'h001D;
    minActive = 99;
    run(40);
    check("glitch_low_min", 32'(minActive), 4);

    // one-cycle reset while keys stay held
    sw = 16'h001F;
    run(60);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkAllZero("midreset");
    t = 0;
    while (activeVoices !== 3'd4 && t < 40) begin
      tick();
      t++;
    end
    check("midreset_active", 32'(activeVoices), 4);
    check("midreset_latency_ok", 32'(t <= 26), 1);

    // random key sets checked in steady state
    for (int n = 0; n < 20; n++) begin
      r  = 16'($urandom_range(0, 65535) & $urandom_range(0, 65535));
      sw = r;
      run(60);
      dropSeen = 0;
      run(32);
      pop = popc(r);
      expDrops = (pop > 4) ? 2 * (pop - 4) : 0;
      check("rand_active", 32'(activeVoices), (pop > 4) ? 4 : pop);
      check("rand_topvalid", 32'(topKeyValid), 32'(r != 0));
      if (r != 0) check("rand_topkey", 32'(topKey), lowest(r));
      check("rand_drops", 32'(dropSeen), expDrops);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
